// File: rtl/ucode_pkg.sv
// Shared microcode definitions: microword layout, sequencing/condition codes,
// controller states and the ALU function-select values this sequencer emits.
package ucode_pkg;

    localparam int SEQ_MSB      = 31;
    localparam int SEQ_LSB      = 28;
    localparam int FSEL_MSB     = 27;
    localparam int FSEL_LSB     = 24;
    localparam int CIN_SRC_BIT  = 23;
    localparam int CIN_K_BIT    = 22;
    localparam int ASEL_MSB     = 21;
    localparam int ASEL_LSB     = 19;
    localparam int BSEL_MSB     = 18;
    localparam int BSEL_LSB     = 16;
    localparam int WSEL_MSB     = 15;
    localparam int WSEL_LSB     = 13;
    localparam int WEN_BIT      = 12;
    localparam int FLAG_UPD_BIT = 11;
    localparam int COND_MSB     = 10;
    localparam int COND_LSB     = 8;
    localparam int TARGET_MSB   = 7;
    localparam int TARGET_LSB   = 0;

    localparam logic [3:0] SEQ_NEXT  = 4'd0;
    localparam logic [3:0] SEQ_JMP   = 4'd1;
    localparam logic [3:0] SEQ_JCOND = 4'd2;
    localparam logic [3:0] SEQ_CALL  = 4'd3;
    localparam logic [3:0] SEQ_RET   = 4'd4;
    localparam logic [3:0] SEQ_HALT  = 4'd5;

    localparam logic [2:0] COND_ALWAYS = 3'd0;
    localparam logic [2:0] COND_Z      = 3'd1;
    localparam logic [2:0] COND_NZ     = 3'd2;
    localparam logic [2:0] COND_S      = 3'd3;
    localparam logic [2:0] COND_C      = 3'd4;
    localparam logic [2:0] COND_NC     = 3'd5;
    localparam logic [2:0] COND_V      = 3'd6;
    localparam logic [2:0] COND_NV     = 3'd7;

    localparam int PSW_Z = 3;
    localparam int PSW_S = 2;
    localparam int PSW_C = 1;
    localparam int PSW_V = 0;

    localparam logic [3:0] FSEL_TSA = 4'd0;
    localparam logic [3:0] FSEL_ADD = 4'd3;
    localparam logic [3:0] FSEL_RLC = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2,
        ST_HALT  = 2'd3
    } state_e;

    function automatic logic cond_met(input logic [2:0] cond, input logic [3:0] psw);
        logic met;
        case (cond)
            COND_ALWAYS: met = 1'b1;
            COND_Z:      met = psw[PSW_Z];
            COND_NZ:     met = ~psw[PSW_Z];
            COND_S:      met = psw[PSW_S];
            COND_C:      met = psw[PSW_C];
            COND_NC:     met = ~psw[PSW_C];
            COND_V:      met = psw[PSW_V];
            COND_NV:     met = ~psw[PSW_V];
            default:     met = 1'b0;
        endcase
        return met;
    endfunction

endpackage

// File: rtl/ustack.sv
// Return-address LIFO for CALL/RET; overflowing pushes and underflowing pops
// are ignored here so the caller can flag them as faults.
module ustack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] push_data,
    output logic [W-1:0] top,
    output logic         full,
    output logic         empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [CW-1:0] count_r;
    logic [AW-1:0] wr_idx_s;
    logic [AW-1:0] rd_idx_s;

    assign wr_idx_s = AW'(count_r);
    assign rd_idx_s = AW'(count_r - CW'(1'b1));
    assign full     = (count_r == CW'(DEPTH));
    assign empty    = (count_r == CW'(1'b0));
    assign top      = mem_r[rd_idx_s];

    // Entry storage and occupancy count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= CW'(1'b0);
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= W'(1'b0);
            end
        end else if (clear) begin
            count_r <= CW'(1'b0);
        end else if (push && !full) begin
            mem_r[wr_idx_s] <= push_data;
            count_r         <= count_r + CW'(1'b1);
        end else if (pop && !empty) begin
            count_r <= count_r - CW'(1'b1);
        end
    end

endmodule

// File: rtl/micro_sequencer.sv
// Microprogrammed controller for the 16-bit ALU: fetches microwords, decodes
// ALU/register-file controls in EXEC, latches flags and sequences the micro-PC.
module micro_sequencer
    import ucode_pkg::*;
#(
    parameter int UPC_W       = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [UPC_W-1:0] START_ADDR,
    output logic [UPC_W-1:0] UADDR,
    input  logic [31:0]      UWORD,
    output logic [3:0]       FSEL,
    output logic             CIN,
    output logic [2:0]       ASEL,
    output logic [2:0]       BSEL,
    output logic [2:0]       WSEL,
    output logic             WEN,
    input  logic             Z,
    input  logic             S,
    input  logic             C,
    input  logic             V,
    output logic [3:0]       PSW,
    output logic             BUSY,
    output logic             HALTED,
    output logic             ERR
);

    state_e           state_r;
    logic [UPC_W-1:0] upc_r;
    logic [3:0]       psw_r;
    logic             err_r;

    logic [3:0]       seq_s;
    logic             in_exec_s;
    logic             legal_s;
    logic             push_s;
    logic             pop_s;
    logic             fault_s;
    logic             clear_s;
    logic [UPC_W-1:0] upc_inc_s;
    logic [UPC_W-1:0] target_s;
    logic [UPC_W-1:0] next_upc_s;
    logic [UPC_W-1:0] stack_top_s;
    logic             stack_full_s;
    logic             stack_empty_s;

    assign UADDR  = upc_r;
    assign PSW    = psw_r;
    assign ERR    = err_r;
    assign BUSY   = (state_r == ST_FETCH) || (state_r == ST_EXEC);
    assign HALTED = (state_r == ST_HALT);

    // Microword decode and next-address selection for the EXEC cycle.
    always_comb begin
        seq_s      = UWORD[SEQ_MSB:SEQ_LSB];
        in_exec_s  = (state_r == ST_EXEC);
        legal_s    = (seq_s <= SEQ_HALT);
        upc_inc_s  = upc_r + UPC_W'(1'b1);
        target_s   = UPC_W'(UWORD[TARGET_MSB:TARGET_LSB]);
        push_s     = in_exec_s && (seq_s == SEQ_CALL) && !stack_full_s;
        pop_s      = in_exec_s && (seq_s == SEQ_RET) && !stack_empty_s;
        fault_s    = in_exec_s && (((seq_s == SEQ_CALL) && stack_full_s) ||
                                   ((seq_s == SEQ_RET) && stack_empty_s));
        clear_s    = (state_r == ST_HALT) && START;
        case (seq_s)
            SEQ_NEXT:  next_upc_s = upc_inc_s;
            SEQ_JMP:   next_upc_s = target_s;
            SEQ_JCOND: next_upc_s = cond_met(UWORD[COND_MSB:COND_LSB], psw_r) ? target_s : upc_inc_s;
            SEQ_CALL:  next_upc_s = target_s;
            SEQ_RET:   next_upc_s = stack_top_s;
            default:   next_upc_s = upc_r;
        endcase
    end

    // ALU and register-file controls are live only in EXEC; illegal words never write.
    always_comb begin
        if (in_exec_s) begin
            FSEL = UWORD[FSEL_MSB:FSEL_LSB];
            CIN  = UWORD[CIN_SRC_BIT] ? psw_r[PSW_C] : UWORD[CIN_K_BIT];
            ASEL = UWORD[ASEL_MSB:ASEL_LSB];
            BSEL = UWORD[BSEL_MSB:BSEL_LSB];
            WSEL = UWORD[WSEL_MSB:WSEL_LSB];
            WEN  = UWORD[WEN_BIT] && legal_s;
        end else begin
            FSEL = FSEL_TSA;
            CIN  = 1'b0;
            ASEL = 3'd0;
            BSEL = 3'd0;
            WSEL = 3'd0;
            WEN  = 1'b0;
        end
    end

    // Controller FSM with micro-PC, status word and sticky error.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_r <= ST_IDLE;
            upc_r   <= UPC_W'(1'b0);
            psw_r   <= 4'd0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (START) begin
                        upc_r   <= START_ADDR;
                        state_r <= ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    state_r <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (UWORD[FLAG_UPD_BIT] && legal_s) begin
                        psw_r <= {Z, S, C, V};
                    end
                    if (!legal_s || fault_s) begin
                        err_r   <= 1'b1;
                        state_r <= ST_HALT;
                    end else if (seq_s == SEQ_HALT) begin
                        state_r <= ST_HALT;
                    end else begin
                        upc_r   <= next_upc_s;
                        state_r <= ST_FETCH;
                    end
                end
                ST_HALT: begin
                    if (START) begin
                        upc_r   <= START_ADDR;
                        err_r   <= 1'b0;
                        state_r <= ST_FETCH;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    ustack #(
        .DEPTH (STACK_DEPTH),
        .W     (UPC_W)
    ) u_stack (
        .clk       (CLK),
        .rst_n     (RST_N),
        .clear     (clear_s),
        .push      (push_s),
        .pop       (pop_s),
        .push_data (upc_inc_s),
        .top       (stack_top_s),
        .full      (stack_full_s),
        .empty     (stack_empty_s)
    );

endmodule
